// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte-addressed big-endian data memory,
// branch resolution and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        Branch_in,
    input  logic        zero_in,
    input  logic [1:0]  load_mode_in,
    input  logic [4:0]  writebackDestination_in,
    input  logic [31:0] aluResult_in,
    input  logic [31:0] rt_in,
    input  logic [31:0] pc_in,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [4:0]  writebackDestination_out,
    output logic [31:0] aluResult_out,
    output logic [31:0] readData_out,
    output logic        misaligned_out
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam logic [1:0]  MODE_W  = 2'd0;
    localparam logic [1:0]  MODE_H  = 2'd1;
    localparam logic [1:0]  MODE_BS = 2'd2;

    logic [DATA_W-1:0]    mem [DEPTH_WORDS];

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           offset;
    logic                 misaligned_c;
    logic [DATA_W-1:0]    rd_word;
    logic [15:0]          rd_half;
    logic [7:0]           rd_byte;
    logic [DATA_W-1:0]    load_data;
    logic [LANES-1:0]     byte_en;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_en;

    assign pc_src        = Branch_in & zero_in;
    assign branch_target = pc_in;

    assign word_idx = aluResult_in[ADDR_BITS+1:2];
    assign offset   = aluResult_in[1:0];
    assign rd_word  = mem[word_idx];
    assign wr_en    = rst_n & MemWrite_in & ~stall;

    // Misaligned word/half accesses fall back to the naturally aligned address.
    always_comb begin
        misaligned_c = 1'b0;
        if (load_mode_in == MODE_W)
            misaligned_c = (offset != 2'd0);
        else if (load_mode_in == MODE_H)
            misaligned_c = offset[0];
    end

    // Big-endian lane selection and extension of load data.
    always_comb begin
        rd_half   = offset[1] ? rd_word[15:0] : rd_word[31:16];
        rd_byte   = rd_word[31:24];
        load_data = rd_word;
        case (offset)
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        case (load_mode_in)
            MODE_W:  load_data = rd_word;
            MODE_H:  load_data = {{16{rd_half[15]}}, rd_half};
            MODE_BS: load_data = {{24{rd_byte[7]}}, rd_byte};
            default: load_data = {24'd0, rd_byte};
        endcase
    end

    // Store data replicated across lanes; byte enables pick the target lanes.
    always_comb begin
        byte_en = 4'b1111;
        wr_data = rt_in;
        case (load_mode_in)
            MODE_W: begin
                byte_en = 4'b1111;
                wr_data = rt_in;
            end
            MODE_H: begin
                byte_en = offset[1] ? 4'b0011 : 4'b1100;
                wr_data = {2{rt_in[15:0]}};
            end
            default: begin
                byte_en = 4'b1000 >> offset;
                wr_data = {4{rt_in[7:0]}};
            end
        endcase
    end

    // Data array is not reset; the write is dropped while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (byte_en[i])
                    mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_out             <= 1'b0;
            MemToReg_out             <= 1'b0;
            writebackDestination_out <= 5'd0;
            aluResult_out            <= 32'd0;
            readData_out             <= 32'd0;
            misaligned_out           <= 1'b0;
        end else if (!stall) begin
            RegWrite_out             <= RegWrite_in;
            MemToReg_out             <= MemToReg_in;
            writebackDestination_out <= writebackDestination_in;
            aluResult_out            <= aluResult_in;
            readData_out             <= MemRead_in ? load_data : 32'd0;
            misaligned_out           <= (MemRead_in | MemWrite_in) & misaligned_c;
        end
    end

endmodule
